// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage MIPS-style core.
//
// Handles exception/ERET flush, multi-cycle divide freeze, an optional
// MTC0 -> MFC0 interlock and the classic load-use stall.
// Outputs are prioritised as
//   Exc_Flush > divide busy > CP0 interlock > load-use > default.
//
// Optional feature macro: HAZARD_CP0_INTERLOCK_EN
//   defined   : ID_MFC0 & EXE_MTC0 stalls IF/ID for one cycle and bubbles ID/EXE.
//   undefined : ID_MFC0 / EXE_MTC0 are ignored; the CP0 value is bypassed.
//
// Parameter
//   DIV_CYCLES    EXE-stage cycles a divide occupies (2..32)
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ID_rs, ID_rt, ID_UsesRt  source operands of the instruction in ID
//   EXE_Dst, EXE_RFWr        destination / GPR write of the instruction in EXE
//   EXE_MemRd                EXE instruction is a load
//   EXE_DivStart             DIV/DIVU in EXE, held while it stays there
//   Exc_Flush                exception / ERET flush request
//   ID_MFC0, EXE_MTC0        CP0 access flags for the interlock
//   PC_Wr, IF_ID_Wr, ID_EXE_Wr                 register write enables
//   IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush   bubble inserts
//   Div_Busy                 divider occupies EXE (pipeline frozen)
//   Div_Count                remaining divide cycles
//
// Divide FSM
//   state | meaning
//   IDLE  | no divide in flight; a DivStart is accepted here
//   BUSY  | divide running, Div_Count counts down to 0
//   DONE  | result ready, one-cycle release of the freeze

module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UsesRt,
    input  logic [4:0] EXE_Dst,
    input  logic       EXE_RFWr,
    input  logic       EXE_MemRd,
    input  logic       EXE_DivStart,
    input  logic       Exc_Flush,
    input  logic       ID_MFC0,
    input  logic       EXE_MTC0,
    output logic       PC_Wr,
    output logic       IF_ID_Wr,
    output logic       ID_EXE_Wr,
    output logic       IF_ID_Flush,
    output logic       ID_EXE_Flush,
    output logic       EXE_MEM_Flush,
    output logic       Div_Busy,
    output logic [5:0] Div_Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    div_state_t state;
    logic       load_use;
    logic       cp0_hit;

    always_ff @(posedge clk) begin
        if (rst || Exc_Flush) begin
            // Exception flush aborts any divide in flight.
            state     <= IDLE;
            Div_Count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EXE_DivStart) begin
                        state     <= BUSY;
                        Div_Count <= DIV_LOAD;
                    end
                end
                BUSY: begin
                    if (Div_Count == 6'd0) begin
                        state <= DONE;
                    end else begin
                        Div_Count <= Div_Count - 6'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    Div_Count <= '0;
                end
            endcase
        end
    end

    // Busy already in the accepting IDLE cycle so the divide's first EXE
    // cycle is frozen as well.
    assign Div_Busy = ~Exc_Flush &
                      ((state == BUSY) || ((state == IDLE) && EXE_DivStart));

    // Writes to $zero never produce a real dependency.
    assign load_use = EXE_MemRd & EXE_RFWr & (EXE_Dst != 5'd0) &
                      ((ID_rs == EXE_Dst) | (ID_UsesRt & (ID_rt == EXE_Dst)));

`ifdef HAZARD_CP0_INTERLOCK_EN
    assign cp0_hit = ID_MFC0 & EXE_MTC0;
`else
    logic cp0_unused;
    assign cp0_unused = ID_MFC0 ^ EXE_MTC0;
    assign cp0_hit    = 1'b0;
`endif

    always_comb begin
        PC_Wr         = 1'b1;
        IF_ID_Wr      = 1'b1;
        ID_EXE_Wr     = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EXE_Flush  = 1'b0;
        EXE_MEM_Flush = 1'b0;
        if (Exc_Flush) begin
            IF_ID_Flush   = 1'b1;
            ID_EXE_Flush  = 1'b1;
            EXE_MEM_Flush = 1'b1;
        end else if (Div_Busy) begin
            PC_Wr         = 1'b0;
            IF_ID_Wr      = 1'b0;
            ID_EXE_Wr     = 1'b0;
            EXE_MEM_Flush = 1'b1;
        end else if (cp0_hit || load_use) begin
            PC_Wr        = 1'b0;
            IF_ID_Wr     = 1'b0;
            ID_EXE_Flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int DIV_CYCLES = 32;

    // Expected output vector: {PC_Wr, IF_ID_Wr, ID_EXE_Wr,
    //                          IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, Div_Busy}
    localparam logic [6:0] O_DEF = 7'b111_000_0;
    localparam logic [6:0] O_LU  = 7'b001_010_0;
    localparam logic [6:0] O_DIV = 7'b000_001_1;
    localparam logic [6:0] O_EXC = 7'b111_111_0;
`ifdef HAZARD_CP0_INTERLOCK_EN
    localparam logic [6:0] O_CP0 = O_LU;
`else
    localparam logic [6:0] O_CP0 = O_DEF;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EXE_Dst;
    logic       ID_UsesRt, EXE_RFWr, EXE_MemRd, EXE_DivStart, Exc_Flush;
    logic       ID_MFC0, EXE_MTC0;
    logic       PC_Wr, IF_ID_Wr, ID_EXE_Wr;
    logic       IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, Div_Busy;
    logic [5:0] Div_Count;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
        .EXE_Dst(EXE_Dst), .EXE_RFWr(EXE_RFWr), .EXE_MemRd(EXE_MemRd),
        .EXE_DivStart(EXE_DivStart), .Exc_Flush(Exc_Flush),
        .ID_MFC0(ID_MFC0), .EXE_MTC0(EXE_MTC0),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EXE_Wr(ID_EXE_Wr),
        .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Flush(ID_EXE_Flush),
        .EXE_MEM_Flush(EXE_MEM_Flush), .Div_Busy(Div_Busy), .Div_Count(Div_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] dst;
        logic       rfwr;
        logic       memrd;
        logic       divst;
        logic       exc;
        logic       mfc0;
        logic       mtc0;
        logic [6:0] exp_o;
    } vec_t;

    vec_t vecs[14];

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0;
        EXE_Dst = 5'd0; EXE_RFWr = 1'b0; EXE_MemRd = 1'b0;
        EXE_DivStart = 1'b0; Exc_Flush = 1'b0;
        ID_MFC0 = 1'b0; EXE_MTC0 = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled 3 units after the rising edge, clear of both edges.
    task automatic check(input string name, input logic [6:0] exp_o,
                         input logic [5:0] exp_cnt);
        logic [6:0] got;
        #2;
        got = {PC_Wr, IF_ID_Wr, ID_EXE_Wr, IF_ID_Flush, ID_EXE_Flush,
               EXE_MEM_Flush, Div_Busy};
        checks++;
        if (got !== exp_o || Div_Count !== exp_cnt) begin
            errors++;
            $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                     name, got, Div_Count, exp_o, exp_cnt);
        end
    endtask

    initial begin
        //            name          rs  rt  ur  dst rfw mrd dvs exc mf mt exp
        vecs[0]  = '{"idle",        0,  0,  0,  0,  0,  0,  0,  0,  0, 0, O_DEF};
        vecs[1]  = '{"lu_rs",       5,  0,  0,  5,  1,  1,  0,  0,  0, 0, O_LU};
        vecs[2]  = '{"lu_zero",     0,  0,  1,  0,  1,  1,  0,  0,  0, 0, O_DEF};
        vecs[3]  = '{"lu_rt",       3,  9,  1,  9,  1,  1,  0,  0,  0, 0, O_LU};
        vecs[4]  = '{"rt_unused",   3,  9,  0,  9,  1,  1,  0,  0,  0, 0, O_DEF};
        vecs[5]  = '{"no_memrd",    7,  0,  0,  7,  1,  0,  0,  0,  0, 0, O_DEF};
        vecs[6]  = '{"no_rfwr",     7,  0,  0,  7,  0,  1,  0,  0,  0, 0, O_DEF};
        vecs[7]  = '{"rs_miss",     6,  8,  1,  7,  1,  1,  0,  0,  0, 0, O_DEF};
        vecs[8]  = '{"exc_over_lu", 5,  0,  0,  5,  1,  1,  0,  1,  0, 0, O_EXC};
        vecs[9]  = '{"cp0",         1,  2,  0,  4,  0,  0,  0,  0,  1, 1, O_CP0};
        vecs[10] = '{"mfc0_only",   1,  2,  0,  4,  0,  0,  0,  0,  1, 0, O_DEF};
        vecs[11] = '{"div_exc",     0,  0,  0,  0,  0,  0,  1,  1,  0, 0, O_EXC};
        vecs[12] = '{"after_dvexc", 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, O_DEF};
        vecs[13] = '{"lu_rt31",     0, 31,  1, 31,  1,  1,  0,  0,  0, 0, O_LU};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset", O_DEF, 6'd0);

        // Single-cycle vectors, all applied with the FSM idle. vecs[11] pairs
        // DivStart with Exc_Flush; vecs[12] confirms the FSM stayed idle.
        for (int i = 0; i < 14; i++) begin
            tick();
            ID_rs = vecs[i].rs; ID_rt = vecs[i].rt; ID_UsesRt = vecs[i].uses_rt;
            EXE_Dst = vecs[i].dst; EXE_RFWr = vecs[i].rfwr; EXE_MemRd = vecs[i].memrd;
            EXE_DivStart = vecs[i].divst; Exc_Flush = vecs[i].exc;
            ID_MFC0 = vecs[i].mfc0; EXE_MTC0 = vecs[i].mtc0;
            check(vecs[i].name, vecs[i].exp_o, 6'd0);
        end

        // Full divide: accept cycle, BUSY counting 30..0, DONE, then IDLE.
        tick();
        idle_inputs();
        EXE_DivStart = 1'b1;
        check("div_accept", O_DIV, 6'd0);
        for (int c = DIV_CYCLES - 2; c >= 0; c--) begin
            tick();
            if (c == 15) begin
                // Load-use and CP0 hits are masked by the freeze.
                EXE_MemRd = 1'b1; EXE_RFWr = 1'b1; EXE_Dst = 5'd4; ID_rs = 5'd4;
                ID_MFC0 = 1'b1; EXE_MTC0 = 1'b1;
            end else begin
                EXE_MemRd = 1'b0; EXE_RFWr = 1'b0; EXE_Dst = 5'd0; ID_rs = 5'd0;
                ID_MFC0 = 1'b0; EXE_MTC0 = 1'b0;
            end
            check((c == 15) ? "div_busy_lu" : "div_busy", O_DIV, 6'(c));
        end
        tick();
        check("div_done", O_DEF, 6'd0);
        tick();
        EXE_DivStart = 1'b0;
        check("div_idle", O_DEF, 6'd0);

        // Abort with Exc_Flush at Div_Count=10.
        tick();
        EXE_DivStart = 1'b1;
        check("abort_accept", O_DIV, 6'd0);
        for (int c = DIV_CYCLES - 2; c > 10; c--) tick();
        tick();
        check("abort_cnt10", O_DIV, 6'd10);
        Exc_Flush = 1'b1;
        check("abort_flush", O_EXC, 6'd10);
        tick();
        Exc_Flush = 1'b0;
        EXE_DivStart = 1'b0;
        check("abort_idle", O_DEF, 6'd0);
        tick();
        check("abort_idle2", O_DEF, 6'd0);

        // Reset at Div_Count=20.
        tick();
        EXE_DivStart = 1'b1;
        for (int c = DIV_CYCLES - 2; c > 20; c--) tick();
        tick();
        check("rst_cnt20", O_DIV, 6'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        EXE_DivStart = 1'b0;
        check("rst_mid_div", O_DEF, 6'd0);

        // Load-use in the DONE cycle is honoured since the freeze is released.
        tick();
        EXE_DivStart = 1'b1;
        for (int c = DIV_CYCLES - 2; c >= 0; c--) tick();
        tick();
        EXE_MemRd = 1'b1; EXE_RFWr = 1'b1; EXE_Dst = 5'd12; ID_rs = 5'd12;
        check("done_lu", O_LU, 6'd0);
        tick();
        idle_inputs();
        check("final_idle", O_DEF, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, want completion");
        $fatal(1);
    end

endmodule
